// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control stage and its 12-bit counter.
package stopwatch_pkg;

  localparam int unsigned COUNT_W = 12;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_STOPPED = 2'b10,
    ST_LAP     = 2'b11
  } state_t;

  // Control bundle presented to the counter.
  typedef struct packed {
    logic count_init;
    logic count_enb;
    logic latch_count;
  } ctrl_t;

  // The prescaler only advances while the counter is counting.
  function automatic logic is_counting(input state_t s);
    return (s == ST_RUNNING) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter control outputs of the stopwatch control stage.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic               btn_start_stop;
  logic               btn_lap_reset;
  logic               count_init;
  logic               count_enb;
  logic               latch_count;
  logic [STATE_W-1:0] run_state;

  modport master (
    input  btn_start_stop,
    input  btn_lap_reset,
    output count_init,
    output count_enb,
    output latch_count,
    output run_state
  );

  modport slave (
    output btn_start_stop,
    output btn_lap_reset,
    input  count_init,
    input  count_enb,
    input  latch_count,
    input  run_state
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce counter; emits the debounced level and a one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ = (sync_b != btn_level);
  assign accept = differ && (cnt == CNT_LAST);

  // Any cycle where the synchronised input agrees with the level restarts the count.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      sync_a    <= btn_raw;
      sync_b    <= sync_a;
      btn_press <= accept & sync_b;
      if (accept) begin
        btn_level <= sync_b;
        cnt       <= '0;
      end else if (differ) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons drive a run/stop/lap FSM and a tick prescaler feeding the counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic              sys_clk,
  input  logic              reset,
  stopwatch_ctrl_if.master  bus
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

  state_t               state;
  state_t               state_n;
  logic [PRESC_W-1:0]   presc;
  logic [PRESC_W-1:0]   presc_n;
  ctrl_t                ctrl_q;
  ctrl_t                ctrl_d;
  logic                 init_pending;
  logic                 init_req;
  logic                 ss_press;
  logic                 lr_press;
  logic                 ss_level;
  logic                 lr_level;
  logic                 levels_unused;

  assign levels_unused = ss_level ^ lr_level;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .btn_raw   (bus.btn_start_stop),
    .btn_level (ss_level),
    .btn_press (ss_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .btn_raw   (bus.btn_lap_reset),
    .btn_level (lr_level),
    .btn_press (lr_press)
  );

  // Next state, prescaler and registered control outputs; start/stop has priority over lap/reset.
  always_comb begin
    state_n  = state;
    presc_n  = presc;
    ctrl_d   = '0;
    init_req = init_pending;

    case (state)
      ST_IDLE: begin
        if (ss_press)      state_n  = ST_RUNNING;
        else if (lr_press) init_req = 1'b1;
      end
      ST_RUNNING: begin
        if (ss_press)      state_n = ST_STOPPED;
        else if (lr_press) state_n = ST_LAP;
      end
      ST_LAP: begin
        if (ss_press)      state_n = ST_STOPPED;
        else if (lr_press) state_n = ST_RUNNING;
      end
      ST_STOPPED: begin
        if (ss_press) begin
          state_n = ST_RUNNING;
        end else if (lr_press) begin
          state_n  = ST_IDLE;
          init_req = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A wrap on the cycle the state is left still belongs to the old state.
    if (is_counting(state)) begin
      if (presc == TICK_LAST) begin
        presc_n          = '0;
        ctrl_d.count_enb = 1'b1;
      end else begin
        presc_n = presc + PRESC_W'(1);
      end
    end

    if (init_req) presc_n = '0;

    ctrl_d.count_init  = init_req;
    ctrl_d.latch_count = (state_n == ST_LAP);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      presc        <= '0;
      ctrl_q       <= '0;
      init_pending <= 1'b1;
    end else begin
      state        <= state_n;
      presc        <= presc_n;
      ctrl_q       <= ctrl_d;
      init_pending <= 1'b0;
    end
  end

  assign bus.count_init  = ctrl_q.count_init;
  assign bus.count_enb   = ctrl_q.count_enb;
  assign bus.latch_count = ctrl_q.latch_count;
  assign bus.run_state   = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus schedules expected output events, a monitor matches observed ones.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int TICK_DIV = 10;
  localparam int DEB      = 4;
  localparam int LAT      = 2 + DEB + 1;
  localparam int K_INIT   = 0;
  localparam int K_ENB    = 1;
  localparam int K_STATE  = 2;
  localparam int K_LATCH  = 3;
  localparam int NEVER    = 1 << 30;

  typedef struct {
    int kind;
    int val;
    int at;
  } ev_t;

  logic sys_clk = 1'b0;
  logic reset;

  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  ev_t        exp_q[$];
  int         total = 0;
  int         bad   = 0;
  bit         mon_en = 1'b0;
  logic [1:0] prev_state = 2'b00;
  logic       prev_latch = 1'b0;

  // Expected tick schedule: next tick edge, last edge ticks may occur, cycles left when stopped.
  int nt      = 0;
  int run_end = 0;
  int rem     = TICK_DIV;
  bit active  = 1'b0;

  function automatic string kname(input int kind);
    case (kind)
      K_INIT:  return "count_init";
      K_ENB:   return "count_enb";
      K_STATE: return "run_state";
      default: return "latch_count";
    endcase
  endfunction

  task automatic push_ev(input int kind, input int val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic push_ticks(input int upto);
    while (active && nt <= upto && nt <= run_end) begin
      push_ev(K_ENB, 1, nt);
      nt += TICK_DIV;
    end
  endtask

  task automatic adv(input int n);
    push_ticks(cyc + n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic start_run(input int entry, input int first_gap);
    nt      = entry + first_gap;
    run_end = NEVER;
    active  = 1'b1;
  endtask

  task automatic stop_run(input int last_edge);
    run_end = last_edge;
    push_ticks(last_edge);
    rem     = nt - last_edge;
    active  = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, req);
    end
  endtask

  task automatic observe(input int kind, input int val);
    int idx = -1;
    foreach (exp_q[i])
      if (idx < 0 && exp_q[i].kind == kind && exp_q[i].at == cyc) idx = i;
    total++;
    if (idx < 0) begin
      bad++;
      $display("FAIL unexpected %s at cycle %0d: got %0d want no event", kname(kind), cyc, val);
    end else begin
      if (exp_q[idx].val != val) begin
        bad++;
        $display("FAIL %s at cycle %0d: got %0d want %0d", kname(kind), cyc, val, exp_q[idx].val);
      end
      exp_q.delete(idx);
    end
  endtask

  // Monitor: every output pulse or level change must match a scheduled event.
  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (bus.count_init)               observe(K_INIT, 1);
      if (bus.count_enb)                observe(K_ENB, 1);
      if (bus.run_state !== prev_state) observe(K_STATE, int'(bus.run_state));
      if (bus.latch_count !== prev_latch) observe(K_LATCH, int'(bus.latch_count));
    end
    prev_state = bus.run_state;
    prev_latch = bus.latch_count;
  end

  initial begin
    int g;
    int s;
    reset = 1'b1;
    bus.btn_start_stop = 1'b0;
    bus.btn_lap_reset  = 1'b0;
    repeat (3) @(negedge sys_clk);

    check("reset_run_state", int'(bus.run_state), 0);
    check("reset_latch", int'(bus.latch_count), 0);
    check("reset_count_enb", int'(bus.count_enb), 0);
    check("reset_count_init", int'(bus.count_init), 0);

    // Release reset: one count_init pulse, then silence for 50 cycles.
    mon_en = 1'b1;
    reset  = 1'b0;
    push_ev(K_INIT, 1, cyc + 1);
    adv(50);

    // lr in IDLE: stays IDLE, one count_init pulse.
    g = cyc; bus.btn_lap_reset = 1'b1;
    push_ev(K_INIT, 1, g + LAT);
    adv(10); bus.btn_lap_reset = 1'b0; adv(10);

    // ss held 20 cycles: single press, RUNNING, first tick 10 cycles after entry.
    g = cyc; bus.btn_start_stop = 1'b1;
    push_ev(K_STATE, 1, g + LAT);
    start_run(g + LAT, 10);
    adv(20); bus.btn_start_stop = 1'b0; adv(15);

    // Bounce 1,0,1,0 then hold: one press, STOPPED 7 cycles after final rise.
    bus.btn_start_stop = 1'b1; adv(1);
    bus.btn_start_stop = 1'b0; adv(1);
    bus.btn_start_stop = 1'b1; adv(1);
    bus.btn_start_stop = 1'b0; adv(1);
    bus.btn_start_stop = 1'b1;
    g = cyc;
    stop_run(g + LAT);
    push_ev(K_STATE, 2, g + LAT);
    adv(12); bus.btn_start_stop = 1'b0; adv(12);

    // Resume keeps the partial tick.
    g = cyc; bus.btn_start_stop = 1'b1;
    push_ev(K_STATE, 1, g + LAT);
    start_run(g + LAT, rem);
    adv(10); bus.btn_start_stop = 1'b0; adv(10);

    // RUNNING -> LAP (latch set, ticks continue) -> RUNNING (latch clear).
    g = cyc; bus.btn_lap_reset = 1'b1;
    push_ev(K_STATE, 3, g + LAT);
    push_ev(K_LATCH, 1, g + LAT);
    adv(10); bus.btn_lap_reset = 1'b0; adv(25);
    g = cyc; bus.btn_lap_reset = 1'b1;
    push_ev(K_STATE, 1, g + LAT);
    push_ev(K_LATCH, 0, g + LAT);
    adv(10); bus.btn_lap_reset = 1'b0; adv(10);

    // Stop with prescaler at 6, wait, resume: first tick 4 cycles after re-entry.
    push_ticks(cyc);
    s = nt + 6;
    adv(s - LAT - cyc);
    bus.btn_start_stop = 1'b1;
    push_ev(K_STATE, 2, s);
    stop_run(s);
    adv(10); bus.btn_start_stop = 1'b0; adv(20);
    g = cyc; bus.btn_start_stop = 1'b1;
    push_ev(K_STATE, 1, g + LAT);
    start_run(g + LAT, 4);
    adv(10); bus.btn_start_stop = 1'b0; adv(10);

    // STOPPED, then lr -> IDLE with one count_init pulse.
    g = cyc; bus.btn_start_stop = 1'b1;
    push_ev(K_STATE, 2, g + LAT);
    stop_run(g + LAT);
    adv(10); bus.btn_start_stop = 1'b0; adv(10);
    g = cyc; bus.btn_lap_reset = 1'b1;
    push_ev(K_STATE, 0, g + LAT);
    push_ev(K_INIT, 1, g + LAT);
    adv(10); bus.btn_lap_reset = 1'b0; adv(10);

    // Prescaler was cleared: a fresh run ticks 10 cycles after entry.
    g = cyc; bus.btn_start_stop = 1'b1;
    push_ev(K_STATE, 1, g + LAT);
    start_run(g + LAT, 10);
    adv(10); bus.btn_start_stop = 1'b0; adv(13);
    g = cyc; bus.btn_start_stop = 1'b1;
    push_ev(K_STATE, 2, g + LAT);
    stop_run(g + LAT);
    adv(10); bus.btn_start_stop = 1'b0; adv(10);

    // Both buttons together in STOPPED: start/stop wins, no count_init.
    g = cyc; bus.btn_start_stop = 1'b1; bus.btn_lap_reset = 1'b1;
    push_ev(K_STATE, 1, g + LAT);
    start_run(g + LAT, rem);
    adv(10); bus.btn_start_stop = 1'b0; bus.btn_lap_reset = 1'b0; adv(10);

    // Enter LAP, then reset mid-operation.
    g = cyc; bus.btn_lap_reset = 1'b1;
    push_ev(K_STATE, 3, g + LAT);
    push_ev(K_LATCH, 1, g + LAT);
    adv(10); bus.btn_lap_reset = 1'b0; adv(12);
    reset = 1'b1;
    stop_run(cyc);
    push_ev(K_STATE, 0, cyc + 1);
    push_ev(K_LATCH, 0, cyc + 1);
    adv(3);
    check("midreset_run_state", int'(bus.run_state), 0);
    check("midreset_latch", int'(bus.latch_count), 0);
    check("midreset_count_enb", int'(bus.count_enb), 0);
    reset = 1'b0;
    push_ev(K_INIT, 1, cyc + 1);
    adv(20);

    foreach (exp_q[i]) begin
      total++;
      bad++;
      $display("FAIL missing %s at cycle %0d: got no event want %0d",
               kname(exp_q[i].kind), exp_q[i].at, exp_q[i].val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control stage directly upstream of the 12-bit stopwatch counter.
- Turns two raw push-buttons (start/stop, lap/reset) into the counter's control inputs: count_init, count_enb and latch_count.
- Contains a run/stop/lap state machine, a button synchroniser and debouncer, and a prescaler that makes the count_enb tick pulses.
- Outputs wire straight to the counter's same-named inputs; the counter's reset_n is driven elsewhere.

Parameters:
- TICK_DIV, 100000: sys_clk cycles per counter tick; minimum 2.
- DEBOUNCE_CYCLES, 20000: consecutive stable synchronised cycles needed before a button level is accepted; minimum 1.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_start_stop  in  1  raw asynchronous button; 1 = pressed.
- btn_lap_reset  in  1  raw asynchronous button; 1 = pressed.
- count_init  out  1  one-cycle pulse that clears the counter.
- count_enb  out  1  one-cycle tick pulse; the counter advances by 1.
- latch_count  out  1  level; 1 = counter display frozen (lap view).
- run_state  out  2  current FSM state, for status LEDs and debug.

Behaviour:
- Reset:
  - state = IDLE; prescaler = 0; synchronisers and debouncers = 0.
  - count_enb = 0, latch_count = 0, run_state = 2'b00.
  - count_init = 0 while reset is high, then exactly one pulse on the first cycle after reset deasserts (init_pending flag).
- Button path:
  - 2-flop synchroniser, then a debounce counter.
  - The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A press pulse is the 0->1 edge of the debounced level, lasting one cycle.
  - Holding a button gives exactly one press.
  - Latency from raw rise (stable) to FSM state change: 2 + DEBOUNCE_CYCLES + 1 cycles.
- States (encoding): IDLE=00, RUNNING=01, STOPPED=10, LAP=11.
  - IDLE:
    - ss press -> RUNNING.
    - lr press -> stay IDLE and pulse count_init.
  - RUNNING:
    - ss press -> STOPPED.
    - lr press -> LAP; latch_count = 1 from the next cycle.
  - LAP (counting continues, display frozen):
    - lr press -> RUNNING; latch_count = 0.
    - ss press -> STOPPED; latch_count = 0.
  - STOPPED:
    - ss press -> RUNNING (resume).
    - lr press -> IDLE and pulse count_init.
- Simultaneous ss and lr presses in the same cycle: ss wins; the lr press is discarded.
- count_init:
  - Registered; high for exactly the one cycle after the transition decision.
  - Never asserted in the same cycle as count_enb.
  - The prescaler is forced to 0 on the same cycle.
- Prescaler:
  - Width $clog2(TICK_DIV).
  - Increments only in RUNNING and LAP.
  - At TICK_DIV-1 it wraps to 0 and count_enb pulses for that one cycle.
  - Held in STOPPED, so resume keeps the partial tick.
  - Cleared on entry to IDLE.
  - First tick after IDLE->RUNNING arrives TICK_DIV cycles after entering RUNNING.
- Leaving RUNNING or LAP in the same cycle as a wrap: the tick pulse is still emitted (it belongs to the old state).
- latch_count is a pure state decode (state == LAP), registered.
- Reset mid-operation (any state, any prescaler value): all of the above reset values apply on the next edge; pending presses are lost.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package stopwatch_pkg:
  - state localparams ST_IDLE, ST_RUNNING, ST_STOPPED, ST_LAP (2-bit);
  - COUNT_W = 12, shared with the counter.
- Sub-module btn_debounce (params DEBOUNCE_CYCLES):
  - ports sys_clk, reset, btn_raw, btn_level, btn_press;
  - contains the synchroniser and debounce counter;
  - instantiated twice.
- FSM and prescaler live in stopwatch_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=10):
- Reset, then release -> count_init high for exactly 1 cycle; run_state=00; count_enb stays 0 for 50 cycles.
- ss held 20 cycles -> RUNNING 7 cycles after rise; count_enb pulses every 10 cycles, first 10 cycles after entry; a second hold produces no extra press.
- Bounce ss 1,0,1,0 in 1-cycle steps, then hold -> one press only; state change 7 cycles after the final rise.
- RUNNING, lr press -> LAP, latch_count=1, ticks continue every 10; lr again -> RUNNING, latch_count=0.
- RUNNING, stop at prescaler=6, wait 30 cycles, resume -> first tick 4 cycles after re-entering RUNNING; then STOPPED, lr -> IDLE with one count_init pulse and prescaler 0.
- ss and lr pressed together in STOPPED -> RUNNING, no count_init; reset asserted in LAP -> latch_count=0 and run_state=00 on next edge.
